// File: rtl/line_burst_adapter_if.sv
// Line-wide cache port plus narrow single-beat memory bus of line_burst_adapter.
// master = the adapter itself; slave = the cache/memory side around it.
interface line_burst_adapter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_SIZE  = 64,
  parameter int BUS_WIDTH  = 32
);
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [LINE_SIZE*8-1:0] mem_write_data;
  logic                   mem_read_en;
  logic                   mem_write_en;
  logic [LINE_SIZE*8-1:0] mem_read_data;
  logic                   mem_ready;
  logic                   bus_req;
  logic                   bus_we;
  logic [ADDR_WIDTH-1:0]  bus_addr;
  logic [BUS_WIDTH-1:0]   bus_wdata;
  logic                   bus_gnt;
  logic                   bus_rvalid;
  logic [BUS_WIDTH-1:0]   bus_rdata;
  logic                   err;

  modport master (
    input  mem_addr, mem_write_data, mem_read_en, mem_write_en,
    input  bus_gnt, bus_rvalid, bus_rdata,
    output mem_read_data, mem_ready, err,
    output bus_req, bus_we, bus_addr, bus_wdata
  );

  modport slave (
    output mem_addr, mem_write_data, mem_read_en, mem_write_en,
    output bus_gnt, bus_rvalid, bus_rdata,
    input  mem_read_data, mem_ready, err,
    input  bus_req, bus_we, bus_addr, bus_wdata
  );
endinterface

// File: rtl/line_burst_adapter.sv
// Splits whole-line fills/writebacks into single-beat narrow-bus transfers and reassembles fills.
// Optional per-beat watchdog: define LINE_BURST_TIMEOUT_EN.
module line_burst_adapter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int LINE_SIZE      = 64,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  line_burst_adapter_if.master bus
);
  localparam int LINE_W  = LINE_SIZE * 8;
  localparam int BEATS   = LINE_W / BUS_WIDTH;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BEAT_SH = $clog2(BUS_WIDTH / 8);
  localparam int WORD_SH = $clog2(BUS_WIDTH);
  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LINE_SIZE - 1);

  if (BEATS < 2 || (LINE_W % BUS_WIDTH) != 0 || (BEATS & (BEATS - 1)) != 0 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("line_burst_adapter: unsupported parameter combination");
  end

  typedef enum logic [2:0] {IDLE, WR_REQ, RD_REQ, RD_WAIT, DONE, GAP} state_t;

  state_t                      state, state_nxt;
  logic [BEAT_W-1:0]           beat;
  logic [ADDR_WIDTH-1:0]       base;
  logic [LINE_W-1:0]           wr_line;
  logic [LINE_W-1:0]           rd_line;
  logic [BEAT_W+WORD_SH-1:0]   slice_lo;
  logic                        accept_wr, accept_rd, beat_adv, rd_store;
  logic                        last, req, to_hit;

  assign last     = (beat == LAST_BEAT);
  assign req      = (state == WR_REQ) || (state == RD_REQ);
  assign slice_lo = {beat, {WORD_SH{1'b0}}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // to_hit can only fire in a waiting state with no handshake this cycle
  always_comb begin
    state_nxt = state;
    accept_wr = 1'b0;
    accept_rd = 1'b0;
    beat_adv  = 1'b0;
    rd_store  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.mem_write_en) begin
          accept_wr = 1'b1;
          state_nxt = WR_REQ;
        end else if (bus.mem_read_en) begin
          accept_rd = 1'b1;
          state_nxt = RD_REQ;
        end
      end
      WR_REQ: begin
        if (bus.bus_gnt) begin
          if (last) state_nxt = DONE;
          else      beat_adv  = 1'b1;
        end else if (to_hit) begin
          state_nxt = DONE;
        end
      end
      RD_REQ: begin
        if (bus.bus_gnt)   state_nxt = RD_WAIT;
        else if (to_hit)   state_nxt = DONE;
      end
      RD_WAIT: begin
        if (bus.bus_rvalid) begin
          rd_store = 1'b1;
          if (last) begin
            state_nxt = DONE;
          end else begin
            beat_adv  = 1'b1;
            state_nxt = RD_REQ;
          end
        end else if (to_hit) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat    <= '0;
      base    <= '0;
      wr_line <= '0;
      rd_line <= '0;
    end else begin
      if (accept_wr || accept_rd) begin
        base <= bus.mem_addr & ~LINE_MASK;
        beat <= '0;
      end else if (beat_adv) begin
        beat <= beat + BEAT_W'(1);
      end
      if (accept_wr) wr_line <= bus.mem_write_data;
      // the fill buffer doubles as mem_read_data, so it is only disturbed by the next read
      if (accept_rd)     rd_line <= '0;
      else if (rd_store) rd_line[slice_lo +: BUS_WIDTH] <= bus.bus_rdata;
    end
  end

  assign bus.bus_req       = req;
  assign bus.bus_we        = (state == WR_REQ);
  assign bus.bus_addr      = req ? base + (ADDR_WIDTH'(beat) << BEAT_SH) : '0;
  assign bus.bus_wdata     = (state == WR_REQ) ? wr_line[slice_lo +: BUS_WIDTH] : '0;
  assign bus.mem_ready     = (state == DONE);
  assign bus.mem_read_data = rd_line;

`ifdef LINE_BURST_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              stalled;
  logic              timed_out;

  assign stalled = (req && !bus.bus_gnt) || (state == RD_WAIT && !bus.bus_rvalid);
  assign to_hit  = stalled && (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt  <= '0;
      timed_out <= 1'b0;
    end else begin
      if (state_nxt != state || !stalled) wait_cnt <= '0;
      else                                wait_cnt <= wait_cnt + WAIT_W'(1);
      if (accept_wr || accept_rd) timed_out <= 1'b0;
      else if (to_hit)            timed_out <= 1'b1;
    end
  end

  assign bus.err = (state == DONE) && timed_out;
`else
  assign to_hit  = 1'b0;
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_line_burst_adapter.sv
// Bench for line_burst_adapter: transaction-level model + bus responder checked every cycle,
// plus directed latency/data literals.
module tb_line_burst_adapter;
  localparam int AW    = 32;
  localparam int LS    = 64;
  localparam int BW    = 32;
  localparam int LW    = LS * 8;
  localparam int BEATS = LW / BW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  line_burst_adapter_if #(.ADDR_WIDTH(AW), .LINE_SIZE(LS), .BUS_WIDTH(BW)) bus_if();

  line_burst_adapter #(
    .ADDR_WIDTH(AW), .LINE_SIZE(LS), .BUS_WIDTH(BW), .TIMEOUT_CYCLES(256)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // responder configuration, written by the main sequence
  int gnt_mode   = 0;
  int stall_beat = -1;
  int stall_left = 0;
  bit no_rvalid  = 1'b0;
  bit chk_en     = 1'b1;

  // transaction model state
  bit            m_busy, m_we, m_rd_out, m_ready, m_gap;
  int            m_beats, rv_cnt;
  logic [AW-1:0] m_base;
  logic [LW-1:0] m_line;

  // observations for the directed literals
  logic [AW-1:0] rec_first_addr, rec_last_addr;
  logic [BW-1:0] rec_first_wdata;
  logic          rec_last_we;
  int            dut_pulses = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] memfn(input logic [AW-1:0] a);
    return {a[17:2], a[17:2]};
  endfunction

  // Monitor/responder: outputs of a cycle are stable at its negedge; inputs driven
  // here are sampled at the following posedge.
  initial begin : monitor
    bit exp_req;
    bus_if.bus_gnt    = 1'b0;
    bus_if.bus_rvalid = 1'b0;
    bus_if.bus_rdata  = '0;
    forever begin
      @(negedge clk);
      if (bus_if.mem_ready === 1'b1) dut_pulses++;
      if (rst) begin
        m_busy = 0; m_we = 0; m_rd_out = 0; m_ready = 0; m_gap = 0; m_beats = 0;
        if (chk_en) begin
          chk("rst_ctrl", LW'({bus_if.bus_req, bus_if.bus_we, bus_if.mem_ready, bus_if.err}), '0);
          chk("rst_addr", LW'(bus_if.bus_addr), '0);
          chk("rst_rdata", bus_if.mem_read_data, '0);
        end
        bus_if.bus_gnt    = 1'b0;
        bus_if.bus_rvalid = 1'b0;
      end else begin
        exp_req = m_busy && !m_rd_out && (m_beats < BEATS);
        if (chk_en) begin
          chk("mem_ready", LW'(bus_if.mem_ready), LW'(m_ready));
          chk("bus_req", LW'(bus_if.bus_req), LW'(exp_req));
          if (exp_req) begin
            chk("bus_we", LW'(bus_if.bus_we), LW'(m_we));
            chk("bus_addr", LW'(bus_if.bus_addr), LW'(m_base + 32'(m_beats * 4)));
            if (m_we) chk("bus_wdata", LW'(bus_if.bus_wdata), LW'(m_line[m_beats*BW +: BW]));
          end
          if (m_ready) begin
            chk("err", LW'(bus_if.err), '0);
            if (!m_we) chk("read_line", bus_if.mem_read_data, m_line);
          end
        end
        // drive grant / read data for this cycle
        bus_if.bus_gnt = (gnt_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        if (stall_left > 0 && exp_req && m_we && m_beats == stall_beat) begin
          bus_if.bus_gnt = 1'b0;
          stall_left--;
        end
        bus_if.bus_rvalid = 1'b0;
        bus_if.bus_rdata  = $urandom;
        if (m_busy && m_rd_out) begin
          if (!no_rvalid) begin
            if (rv_cnt == 0) begin
              bus_if.bus_rvalid = 1'b1;
              bus_if.bus_rdata  = memfn(m_base + 32'(m_beats * 4));
            end else begin
              rv_cnt--;
            end
          end
        end else if (gnt_mode == 1 && !(m_busy && !m_we)) begin
          bus_if.bus_rvalid = ($urandom_range(0, 1) != 0);
        end
        // advance the model to the next cycle
        if (m_ready) begin
          m_ready = 0;
          m_gap   = 1;
        end else if (m_gap) begin
          m_gap = 0;
        end else if (!m_busy) begin
          if (bus_if.mem_write_en || bus_if.mem_read_en) begin
            m_busy  = 1;
            m_we    = bus_if.mem_write_en;
            m_base  = bus_if.mem_addr & ~32'(LS - 1);
            m_beats = 0;
            if (m_we) m_line = bus_if.mem_write_data;
            else for (int k = 0; k < BEATS; k++) m_line[k*BW +: BW] = memfn(m_base + 32'(k * 4));
          end
        end else if (exp_req && bus_if.bus_gnt) begin
          if (m_beats == 0) begin
            rec_first_addr  = bus_if.bus_addr;
            rec_first_wdata = bus_if.bus_wdata;
          end
          rec_last_addr = bus_if.bus_addr;
          rec_last_we   = bus_if.bus_we;
          if (m_we) begin
            m_beats++;
            if (m_beats == BEATS) begin m_busy = 0; m_ready = 1; end
          end else begin
            m_rd_out = 1;
            rv_cnt   = (gnt_mode == 0) ? 0 : int'($urandom_range(0, 2));
          end
        end else if (m_rd_out && bus_if.bus_rvalid) begin
          m_rd_out = 0;
          m_beats++;
          if (m_beats == BEATS) begin m_busy = 0; m_ready = 1; end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int limit, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (bus_if.mem_ready !== 1'b1 && lat < limit);
    if (bus_if.mem_ready !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: got no mem_ready required one within %0d cycles", limit);
    end
  endtask

  task automatic start(input bit wr, input bit rd, input logic [AW-1:0] a, input logic [LW-1:0] line);
    bus_if.mem_addr       = a;
    bus_if.mem_write_data = line;
    bus_if.mem_write_en   = wr;
    bus_if.mem_read_en    = rd;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int k = 0; k < BEATS; k++) l[k*BW +: BW] = $urandom;
    return l;
  endfunction

  initial begin : main
    int            lat, p0, guard;
    bit            wr;
    logic [LW-1:0] line, rdl;

    start(1'b0, 1'b0, '0, '0);
    tick(3);
    rst = 1'b0;
    chk("reset_ready", LW'(bus_if.mem_ready), '0);
    chk("reset_req", LW'(bus_if.bus_req), '0);
    chk("reset_rdata", bus_if.mem_read_data, '0);
    tick(1);

    // aligned read, gnt tied high, rvalid one cycle after gnt
    start(1'b0, 1'b1, 32'h1000, '0);
    wait_ready(100, lat);
    rdl = bus_if.mem_read_data;
    bus_if.mem_read_en = 1'b0;
    chk("rd_latency", LW'(lat), LW'(33));
    chk("rd_word0", LW'(rdl[31:0]), LW'(32'h0400_0400));
    chk("rd_word15", LW'(rdl[511:480]), LW'(32'h040F_040F));
    chk("rd_first_addr", LW'(rec_first_addr), LW'(32'h1000));
    chk("rd_last_addr", LW'(rec_last_addr), LW'(32'h103C));
    tick(2);

    // write with only word 0 non-zero
    line = '0;
    line[31:0] = 32'hDEAD_BEEF;
    start(1'b1, 1'b0, 32'h2000, line);
    wait_ready(100, lat);
    bus_if.mem_write_en = 1'b0;
    chk("wr_latency", LW'(lat), LW'(17));
    chk("wr_first_wdata", LW'(rec_first_wdata), LW'(32'hDEAD_BEEF));
    chk("wr_first_addr", LW'(rec_first_addr), LW'(32'h2000));
    chk("wr_last_addr", LW'(rec_last_addr), LW'(32'h203C));
    tick(2);

    // unaligned read address is line-aligned on the bus
    start(1'b0, 1'b1, 32'h1014, '0);
    wait_ready(100, lat);
    bus_if.mem_read_en = 1'b0;
    chk("unaligned_first_addr", LW'(rec_first_addr), LW'(32'h1000));
    chk("unaligned_latency", LW'(lat), LW'(33));
    tick(2);

    // both enables: write first, then GAP, then the read
    p0 = dut_pulses;
    start(1'b1, 1'b1, 32'h4000, rand_line());
    wait_ready(100, lat);
    bus_if.mem_write_en = 1'b0;
    chk("both_wr_latency", LW'(lat), LW'(17));
    chk("both_first_is_write", LW'(rec_last_we), LW'(1'b1));
    wait_ready(100, lat);
    bus_if.mem_read_en = 1'b0;
    chk("both_rd_latency", LW'(lat), LW'(35));
    chk("both_second_is_read", LW'(rec_last_we), LW'(1'b0));
    chk("both_rd_addr", LW'(rec_first_addr), LW'(32'h4000));
    tick(2);
    chk("both_two_pulses", LW'(dut_pulses - p0), LW'(2));

    // grant withheld 5 cycles on write beat 3
    stall_beat = 3;
    stall_left = 5;
    start(1'b1, 1'b0, 32'h6000, rand_line());
    wait_ready(100, lat);
    bus_if.mem_write_en = 1'b0;
    chk("stall_latency", LW'(lat), LW'(22));
    stall_beat = -1;
    tick(2);

    // randomized traffic
    gnt_mode = 1;
    for (int t = 0; t < 24; t++) begin
      wr = ($urandom_range(0, 1) != 0);
      start(wr, !wr, $urandom, rand_line());
      wait_ready(600, lat);
      bus_if.mem_write_en = 1'b0;
      bus_if.mem_read_en  = 1'b0;
      tick($urandom_range(2, 4));
    end
    gnt_mode = 0;
    tick(4);

    // reset asserted during beat 7 of a read
    start(1'b0, 1'b1, 32'h3000, '0);
    guard = 0;
    while (m_beats != 7 && guard < 100) begin
      tick(1);
      guard++;
    end
    chk("reached_beat7", LW'(m_beats), LW'(7));
    rst = 1'b1;
    bus_if.mem_read_en = 1'b0;
    #1;
    chk("abort_req", LW'(bus_if.bus_req), '0);
    chk("abort_ready", LW'(bus_if.mem_ready), '0);
    chk("abort_addr", LW'(bus_if.bus_addr), '0);
    chk("abort_rdata", bus_if.mem_read_data, '0);
    p0 = dut_pulses;
    tick(2);
    rst = 1'b0;
    tick(40);
    chk("abort_no_pulse", LW'(dut_pulses - p0), '0);
    chk("abort_idle_req", LW'(bus_if.bus_req), '0);

`ifdef LINE_BURST_TIMEOUT_EN
    // read data never returns: watchdog ends the burst on beat 0
    chk_en    = 1'b0;
    no_rvalid = 1'b1;
    start(1'b0, 1'b1, 32'h5000, '0);
    wait_ready(400, lat);
    bus_if.mem_read_en = 1'b0;
    chk("timeout_latency", LW'(lat), LW'(258));
    chk("timeout_err", LW'(bus_if.err), LW'(1'b1));
    chk("timeout_rdata", bus_if.mem_read_data, '0);
    tick(2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/line_burst_adapter.md
Name: line_burst_adapter

Overview:
- Memory-side stage directly downstream of the cache controller's line-wide memory port.
- Converts each whole-line fill or writeback (LINE_SIZE bytes) into BEATS sequential single-beat transfers on a narrow BUS_WIDTH memory bus.
- The read line is reassembled and returned to the cache with a one-cycle mem_ready pulse.

Parameters:
- ADDR_WIDTH, 32, address width of both sides.
- LINE_SIZE, 64, cache line size in bytes.
- BUS_WIDTH, 32, narrow bus data width in bits; BEATS = LINE_SIZE*8/BUS_WIDTH (16 at defaults).
- TIMEOUT_CYCLES, 256, per-beat watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_addr  in  ADDR_WIDTH  line address from cache; low log2(LINE_SIZE) bits ignored.
- mem_write_data  in  LINE_SIZE*8  writeback line.
- mem_read_en  in  1  line fill request, level, held until mem_ready.
- mem_write_en  in  1  line writeback request, level, held until mem_ready.
- mem_read_data  out  LINE_SIZE*8  assembled fill line; valid only while mem_ready=1.
- mem_ready  out  1  one-cycle completion pulse.
- bus_req  out  1  beat request.
- bus_we  out  1  1=write beat, 0=read beat.
- bus_addr  out  ADDR_WIDTH  beat byte address.
- bus_wdata  out  BUS_WIDTH  write beat data.
- bus_gnt  in  1  beat accepted this cycle.
- bus_rvalid  in  1  read beat data valid.
- bus_rdata  in  BUS_WIDTH  read beat data.
- err  out  1  timeout flag, qualified by mem_ready.

Behaviour:
- Reset values:
  - State IDLE; beat counter 0.
  - All outputs 0, including mem_read_data and the write buffer.
  - Assertion mid-burst aborts immediately: no mem_ready, no further bus_req.
- States: IDLE, WR_REQ, RD_REQ, RD_WAIT, DONE, GAP.
- IDLE:
  - If mem_write_en=1: capture line-aligned address and write line, beat=0, go to WR_REQ.
  - Else if mem_read_en=1: capture aligned address, clear the line buffer to 0, beat=0, go to RD_REQ.
  - Write has priority when both enables are high.
- WR_REQ:
  - Drives bus_req=1, bus_we=1.
  - bus_addr = base + beat*(BUS_WIDTH/8).
  - bus_wdata = write line slice [beat*BUS_WIDTH +: BUS_WIDTH].
  - Outputs are held stable until bus_gnt.
  - On bus_gnt: if beat=BEATS-1 go to DONE, else beat+1.
- RD_REQ:
  - Drives bus_req=1, bus_we=0 with the same beat address.
  - On bus_gnt go to RD_WAIT.
- RD_WAIT:
  - bus_req=0.
  - On bus_rvalid: store bus_rdata into slice [beat]. If last beat go to DONE, else beat+1 and go to RD_REQ.
  - bus_rvalid is sampled only in RD_WAIT; the bus guarantees rvalid at least one cycle after gnt; one beat outstanding at most.
- DONE:
  - mem_ready=1 for exactly one cycle.
  - mem_read_data is the assembled line (reads) and is held until the next read acceptance.
  - Next state is GAP.
- GAP:
  - One cycle in which both enables are ignored, so the requester can drop its registered enable; next state is IDLE.
  - The requester must deassert the served enable in the cycle after mem_ready.
- Latency from acceptance edge, with bus_gnt tied high:
  - Write: 16 WR_REQ cycles, mem_ready in cycle 17.
  - Read with rvalid one cycle after gnt: 32 cycles, mem_ready in cycle 33.
- Beat address arithmetic wraps modulo 2^ADDR_WIDTH.
- bus_gnt arriving in any state other than WR_REQ/RD_REQ is ignored.

Optional Feature:
- LINE_BURST_TIMEOUT_EN defined:
  - A per-beat counter clears on each state entry and increments while waiting in WR_REQ, RD_REQ or RD_WAIT.
  - On reaching TIMEOUT_CYCLES: remaining beats are skipped and the block goes to DONE with err=1 during the mem_ready pulse.
  - Unreceived read slices remain 0.
- Undefined: no counter; err tied 0; waits are unbounded.

Test Plan:
- Read, mem_addr=0x1000, bus returns {addr[17:2],addr[17:2]}, gnt=1, rvalid 1 cycle later -> bus_addr 0x1000..0x103C; mem_ready in cycle 33; mem_read_data[31:0]=0x04000400, [511:480]=0x040F040F.
- Write, mem_addr=0x2000, line word0=0xDEADBEEF, others 0, gnt=1 -> 16 beats, first beat wdata 0xDEADBEEF at 0x2000, last beat at 0x203C; mem_ready in cycle 17.
- Unaligned read, mem_addr=0x1014 -> first bus_addr=0x1000.
- Both enables high at 0x4000 -> write burst completes first, then GAP, then read burst to 0x4000; two distinct mem_ready pulses.
- bus_gnt withheld 5 cycles on beat 3 of a write -> bus_addr/bus_wdata stable throughout; total latency grows by 5.
- rst=1 asserted at beat 7 of a read -> all outputs 0 next cycle, no mem_ready. With LINE_BURST_TIMEOUT_EN and rvalid never arriving -> mem_ready and err=1 after 256 wait cycles on beat 0, mem_read_data=0.
